// File: rtl/sysu_counter_pkg.sv
// Shared constants for the sysu presettable up/down counter family.
// Width helpers, direction encodings and a legal-width check.
package sysu_counter_pkg;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 16;

  localparam logic [MAX_WIDTH-1:0] ONES_MAX = '1;
  localparam logic [MAX_WIDTH-1:0] ZERO_MAX = '0;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic logic width_ok(
    input int w
  );
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/sysu_and2.sv
// sysu library two-input AND gate.
// Used to chain RCO into the next stage's ENT.
module sysu_and2 (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a & b;

endmodule

// File: rtl/sysu_counter_tc_detect.sv
// Terminal-count compare: all-ones/TC when counting up, zero when down.
// Purely combinational, no enable qualification.
module sysu_counter_tc_detect #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic [WIDTH-1:0] tc,
  output logic             terminal
);

  import sysu_counter_pkg::*;

  localparam logic [WIDTH-1:0] ZERO = ZERO_MAX[WIDTH-1:0];

  logic hit_up;
  logic hit_down;

  assign hit_up   = (up == DIR_UP) && (q == tc);
  assign hit_down = (up == DIR_DOWN) && (q == ZERO);

  assign terminal = hit_up | hit_down;

endmodule

// File: rtl/sysu_counter4.sv
// Synchronous presettable up/down counter (74169/74163 style).
// SYSU_COUNTER_MODULO_EN adds a programmable terminal count port TC.
module sysu_counter4 #(
  parameter int WIDTH = 4,
  parameter int Delay = 0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
`ifdef SYSU_COUNTER_MODULO_EN
  input  logic [WIDTH-1:0] TC,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  import sysu_counter_pkg::*;

  localparam logic [WIDTH-1:0] ALL_ONES = ONES_MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO     = ZERO_MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  // Delay is a library-interface parameter; this RTL drives outputs
  // with zero delay, so only its legality is checked here.
  generate
    if (!width_ok(WIDTH) || (Delay < 0)) begin : g_bad_cfg
      $error("sysu_counter4: WIDTH must be 2..16 and Delay >= 0");
    end
  endgenerate

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] tc_eff;
  logic             count_en;
  logic             terminal;

`ifdef SYSU_COUNTER_MODULO_EN
  assign tc_eff = TC;
`else
  assign tc_eff = ALL_ONES;
`endif

  assign count_en = ENP & ENT;

  always_comb begin
    q_nxt = q_r;
    if (LOAD) begin
      q_nxt = D;
    end else if (count_en) begin
      if (UP == DIR_UP) begin
        q_nxt = (q_r == tc_eff) ? ZERO : (q_r + ONE);
      end else begin
        q_nxt = (q_r == ZERO) ? tc_eff : (q_r - ONE);
      end
    end
  end

  // Clear written as a multiply so an X on CLR smears every Q bit.
  always_ff @(posedge CLK) begin
    q_r <= q_nxt * {{(WIDTH-1){1'b0}}, ~CLR};
  end

  assign Q = q_r;

  sysu_counter_tc_detect #(
    .WIDTH(WIDTH)
  ) u_tc_detect (
    .q       (q_r),
    .up      (UP),
    .tc      (tc_eff),
    .terminal(terminal)
  );

  sysu_and2 u_rco_and (
    .a(terminal),
    .b(ENT),
    .y(RCO)
  );

endmodule

// File: tb/tb_sysu_counter4.sv
// Directed bench for sysu_counter4: single stage plus a two-stage cascade.
// Define SYSU_COUNTER_MODULO_EN to also exercise the TC port.
module tb_sysu_counter4;

  logic       clk;
  logic       clr;
  logic       load;
  logic [3:0] d;
  logic       enp;
  logic       ent;
  logic       up;
  logic [3:0] q0;
  logic       rco0;

  logic       casc_en;
  logic       ent1;
  logic [3:0] q1;
  logic       rco1;
  logic       load1;
  logic [3:0] d1;

`ifdef SYSU_COUNTER_MODULO_EN
  logic [3:0] tc;
  logic [3:0] tc1;
`endif

  int n_checks;
  int n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sysu_counter4 #(.WIDTH(4), .Delay(0)) u0 (
    .CLK (clk),
    .CLR (clr),
    .LOAD(load),
    .D   (d),
    .ENP (enp),
    .ENT (ent),
    .UP  (up),
`ifdef SYSU_COUNTER_MODULO_EN
    .TC  (tc),
`endif
    .Q   (q0),
    .RCO (rco0)
  );

  sysu_and2 u_casc (
    .a(rco0),
    .b(casc_en),
    .y(ent1)
  );

  sysu_counter4 #(.WIDTH(4), .Delay(0)) u1 (
    .CLK (clk),
    .CLR (clr),
    .LOAD(load1),
    .D   (d1),
    .ENP (enp),
    .ENT (ent1),
    .UP  (up),
`ifdef SYSU_COUNTER_MODULO_EN
    .TC  (tc1),
`endif
    .Q   (q1),
    .RCO (rco1)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clr      = 1'b1;
    load     = 1'b0;
    d        = 4'h0;
    enp      = 1'b0;
    ent      = 1'b0;
    up       = 1'b1;
    casc_en  = 1'b0;
    load1    = 1'b0;
    d1       = 4'h0;
`ifdef SYSU_COUNTER_MODULO_EN
    tc       = 4'hf;
    tc1      = 4'hf;
`endif
    step();
    chk("init_q0", 32'(q0), 32'h0);
    chk("init_q1", 32'(q1), 32'h0);

    // clear from a loaded value
    clr  = 1'b0;
    load = 1'b1;
    d    = 4'ha;
    step();
    chk("load_a", 32'(q0), 32'ha);
    load = 1'b0;
    clr  = 1'b1;
    up   = 1'b0;
    ent  = 1'b1;
    step();
    chk("clr_q", 32'(q0), 32'h0);
    chk("clr_rco_dn", 32'(rco0), 32'h1);
    ent = 1'b0;
    #1;
    chk("clr_rco_ent0", 32'(rco0), 32'h0);

    // up count with wrap
    clr = 1'b0;
    up  = 1'b1;
    enp = 1'b1;
    ent = 1'b1;
    #1;
    chk("up_q_0", 32'(q0), 32'h0);
    chk("up_rco_0", 32'(rco0), 32'h0);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("up_q", 32'(q0), 32'(i % 16));
      chk("up_rco", 32'(rco0), 32'((i % 16) == 15));
    end

    // clear beats load, then load beats count
    step();
    chk("pre_clrld", 32'(q0), 32'h1);
    clr  = 1'b1;
    load = 1'b1;
    d    = 4'h3;
    step();
    chk("clr_over_ld", 32'(q0), 32'h0);
    clr = 1'b0;
    step();
    chk("ld_over_cnt", 32'(q0), 32'h3);

    // down count through zero, then hold
    d = 4'h1;
    step();
    chk("load_1", 32'(q0), 32'h1);
    load = 1'b0;
    up   = 1'b0;
    step();
    chk("dn_q0", 32'(q0), 32'h0);
    chk("dn_rco0", 32'(rco0), 32'h1);
    enp = 1'b0;
    #1;
    chk("rco_no_enp", 32'(rco0), 32'h1);
    enp = 1'b1;
    step();
    chk("dn_wrap", 32'(q0), 32'hf);
    chk("dn_rco_f", 32'(rco0), 32'h0);
    enp = 1'b0;
    step();
    chk("hold_enp0", 32'(q0), 32'hf);
    chk("hold_rco", 32'(rco0), 32'h0);
    up = 1'b1;
    #1;
    chk("rco_up_f", 32'(rco0), 32'h1);
    enp = 1'b1;
    ent = 1'b0;
    step();
    chk("hold_ent0", 32'(q0), 32'hf);
    chk("rco_ent0", 32'(rco0), 32'h0);
    chk("q1_idle", 32'(q1), 32'h0);

    // two-stage cascade
    ent = 1'b1;
    clr = 1'b1;
    step();
    clr     = 1'b0;
    casc_en = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      step();
      chk("casc", 32'({q1, q0}), 32'(i % 256));
    end
    casc_en = 1'b0;

`ifdef SYSU_COUNTER_MODULO_EN
    tc  = 4'd9;
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      step();
      chk("mod_q", 32'(q0), 32'(i % 10));
      chk("mod_rco", 32'(rco0), 32'((i % 10) == 9));
    end
    load = 1'b1;
    d    = 4'd12;
    step();
    load = 1'b0;
    chk("mod_ld12", 32'(q0), 32'd12);
    chk("mod_rco12", 32'(rco0), 32'h0);
    for (int i = 13; i <= 16; i++) begin
      step();
      chk("mod_hi", 32'(q0), 32'(i % 16));
      chk("mod_hi_rco", 32'(rco0), 32'h0);
    end
    up = 1'b0;
    step();
    chk("mod_dn_wrap", 32'(q0), 32'd9);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
